// File: rtl/tick_countdown_timer.sv
// Tick-driven countdown timer: synchronizes slow_clk, reports its edges as one-cycle ticks,
// and counts ticks down from load_value. Define TICK_DUAL_EDGE_EN to tick on both slow_clk edges.
module tick_countdown_timer #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] load_value,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sync_s;
  logic                   sync_vld;
  logic                   hist_q, hist_d;
  logic                   primed_q, primed_d;
  logic                   tick_q, tick_d;
  logic                   edge_det;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       rem_q, rem_d;

  // fill_q marks when the synchronizer output holds a real sample rather than its reset value
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign sync_vld = fill_q[SYNC_STAGES-1];

  always_comb begin
`ifdef TICK_DUAL_EDGE_EN
    edge_det = sync_s ^ hist_q;
`else
    edge_det = sync_s & ~hist_q;
`endif
    // The first valid sample only primes the history flop
    tick_d   = sync_vld & primed_q & edge_det;
    hist_d   = sync_vld ? sync_s : hist_q;
    primed_d = primed_q | sync_vld;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hist_q   <= 1'b0;
      primed_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      primed_q <= primed_d;
      tick_q   <= tick_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (load_value == '0) begin
            state_d = S_DONE;
            rem_d   = '0;
          end else begin
            state_d = S_RUN;
            rem_d   = load_value;
          end
        end
      end
      S_RUN: begin
        // abort outranks a coincident tick
        if (abort) begin
          state_d = S_IDLE;
          rem_d   = '0;
        end else if (tick_q) begin
          if (rem_q <= CNT_W'(1)) begin
            state_d = S_DONE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  assign tick      = tick_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign remaining = rem_q;

endmodule

// File: doc/tick_countdown_timer.md
TICK_COUNTDOWN_TIMER -- requirements
Module: tick_countdown_timer

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- CNT_W, 8: width of load_value and remaining.
- SYNC_STAGES, 2: synchronizer flops on slow_clk (minimum 2).

REQ-002 Ports, one per line: name, direction, width, meaning:
- clk_in, input, 1: single system clock; all logic is on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- slow_clk, input, 1: slow toggling clock from the divider, treated as asynchronous data.
- start, input, 1: level-sampled request to begin a countdown.
- abort, input, 1: cancels a running countdown.
- load_value, input, CNT_W: countdown length in ticks, sampled on accepted start.
- tick, output, 1: one-cycle pulse per detected slow_clk edge.
- busy, output, 1: high while the countdown is in RUN.
- done, output, 1: one-cycle pulse on countdown expiry.
- remaining, output, CNT_W: ticks left in the countdown.

Function
REQ-003 slow_clk SHALL pass through SYNC_STAGES flops, then one history flop; tick SHALL be a registered pulse derived from history vs synchronized value.
REQ-004 Latency: a slow_clk transition first sampled at clk_in edge N SHALL produce tick high for exactly the cycle after edge N+SYNC_STAGES.
REQ-005 Priming: the first valid synchronized sample after reset SHALL load the history flop without generating tick, so a slow_clk already high at reset release produces no tick.
REQ-006 FSM states SHALL be IDLE, RUN and DONE; reset state is IDLE.
REQ-007 IDLE transitions:
- start=1, abort=0, load_value≠0: remaining←load_value, go to RUN.
- start=1, load_value=0: go directly to DONE.
- start=1 and abort=1 together: abort wins; stay in IDLE.
REQ-008 RUN behaviour:
- Each tick decrements remaining by 1.
- A tick while remaining=1 sets remaining←0 and goes to DONE.
- A tick on the same cycle start is accepted SHALL NOT be counted.
REQ-009 RUN with abort=1 SHALL go to IDLE with remaining←0 and no done pulse; abort takes priority over a coincident tick.
REQ-010 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start during DONE is ignored.
REQ-011 busy SHALL be 1 exactly while in RUN; start while busy is ignored, including load_value changes.
REQ-012 remaining SHALL never wrap below 0; it holds its value in IDLE after DONE (0) and after abort (0).
REQ-013 tick SHALL pulse independently of FSM state (free-running edge report).

Reset
REQ-014 Asserting rst SHALL immediately clear:
- synchronizer, history and primed flops;
- tick, busy and done to 0;
- remaining to 0;
- state to IDLE.
REQ-015 Reset asserted mid-RUN SHALL discard the countdown with no done pulse; after release the block behaves as freshly reset, including priming.

Configuration
REQ-016 Macro TICK_DUAL_EDGE_EN:
- Defined: tick fires on both rising and falling synchronized slow_clk edges (two ticks per slow_clk period).
- Undefined: tick fires on rising edges only.
- All other behaviour is identical in both builds.

Verification
REQ-017 Reset release with slow_clk=1 held -> no tick for 10 cycles; first 1→0→1 sequence gives exactly one tick (rising-only build).
REQ-018 slow_clk rises at edge 20 with SYNC_STAGES=2 -> tick high only in cycle after edge 22.
REQ-019 load_value=3, start pulse, then 3 rising edges -> remaining reads 3,2,1,0; done pulses one cycle after the third tick; busy then falls.
REQ-020 load_value=0 with start -> done pulses next cycle; busy never asserts.
REQ-021 load_value=5 running with remaining=2, abort coincident with tick -> IDLE, remaining=0, no done; start+abort in IDLE -> stays IDLE.
REQ-022 TICK_DUAL_EDGE_EN build, load_value=4 -> done after 2 slow_clk periods; rst asserted mid-run -> outputs 0 immediately, no done.
